// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch-path width defaults and fetch FSM state encoding
package cpu_pkg;
    localparam int BUS_WIDTH_DEF = 16;
    localparam int PC_WIDTH_DEF  = 8;
    localparam int TIMEOUT_DEF   = 16;
    typedef enum logic [1:0] {IDLE, REQ, WAIT} fetch_state_t;
endpackage

// File: rtl/pc_reg.sv
// pc_reg: program counter with load (priority) and wrapping increment
module pc_reg #(
    parameter int PC_WIDTH = cpu_pkg::PC_WIDTH_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                inc,
    input  logic                load,
    input  logic [PC_WIDTH-1:0] load_addr,
    output logic [PC_WIDTH-1:0] pc
);
    always_ff @(posedge clk)
        pc <= reset ? '0 : load ? load_addr : inc ? pc + 1'b1 : pc;
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: IDLE/REQ/WAIT fetch FSM with one-deep request queue, jump flush and sticky timeout
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int BUS_WIDTH = BUS_WIDTH_DEF,
    parameter int PC_WIDTH  = PC_WIDTH_DEF,
    parameter int TIMEOUT   = TIMEOUT_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pc_inc,
    input  logic                 imem_read,
    input  logic                 jump,
    input  logic [PC_WIDTH-1:0]  jump_addr,
    output logic [PC_WIDTH-1:0]  imem_addr,
    output logic                 imem_rd_en,
    input  logic [BUS_WIDTH-1:0] imem_rdata,
    input  logic                 imem_rvalid,
    output logic [BUS_WIDTH-1:0] ir,
    output logic                 ir_valid,
    output logic [PC_WIDTH-1:0]  pc,
    output logic                 busy,
    output logic                 fetch_err
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    fetch_state_t state, state_n;
    logic pending, pending_n, rd_en_n, ir_valid_n, err_n;
    logic [TW-1:0] tcnt, tcnt_n;
    logic [PC_WIDTH-1:0] addr_n;
    logic [BUS_WIDTH-1:0] ir_n;

    pc_reg #(.PC_WIDTH(PC_WIDTH)) u_pc (
        .clk(clk), .reset(reset), .inc(pc_inc), .load(jump), .load_addr(jump_addr), .pc(pc)
    );

    assign busy = state != IDLE;

    always_comb begin
        state_n    = state;
        pending_n  = pending | (busy & imem_read);
        tcnt_n     = '0;
        ir_n       = ir;
        ir_valid_n = 1'b0;
        rd_en_n    = 1'b0;
        addr_n     = imem_addr;
        err_n      = fetch_err;
        case (state)
            IDLE: if (imem_read || pending) begin
                state_n   = REQ;
                pending_n = 1'b0;
                rd_en_n   = 1'b1;
                addr_n    = pc;
            end
            REQ: state_n = jump ? IDLE : WAIT;
            WAIT: if (jump) state_n = IDLE;
            else if (imem_rvalid) begin
                state_n    = IDLE;
                ir_n       = imem_rdata;
                ir_valid_n = 1'b1;
            end else if (tcnt == T_LAST) begin
                state_n = IDLE;
                err_n   = 1'b1;
            end else tcnt_n = tcnt + 1'b1;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            pending    <= 1'b0;
            tcnt       <= '0;
            ir         <= '0;
            ir_valid   <= 1'b0;
            imem_rd_en <= 1'b0;
            imem_addr  <= '0;
            fetch_err  <= 1'b0;
        end else begin
            state      <= state_n;
            pending    <= pending_n;
            tcnt       <= tcnt_n;
            ir         <= ir_n;
            ir_valid   <= ir_valid_n;
            imem_rd_en <= rd_en_n;
            imem_addr  <= addr_n;
            fetch_err  <= err_n;
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: table-driven plus directed-sequence check of instr_fetch
module tb_instr_fetch;
    logic clk = 1'b0, reset, pc_inc, imem_read, jump, imem_rd_en, imem_rvalid, ir_valid, busy, fetch_err;
    logic [7:0] jump_addr, imem_addr, pc;
    logic [15:0] imem_rdata, ir;
    int n_vec = 0, n_bad = 0, rd_cnt = 0;

    always #5 clk = ~clk;

    instr_fetch dut (
        .clk(clk), .reset(reset), .pc_inc(pc_inc), .imem_read(imem_read), .jump(jump),
        .jump_addr(jump_addr), .imem_addr(imem_addr), .imem_rd_en(imem_rd_en),
        .imem_rdata(imem_rdata), .imem_rvalid(imem_rvalid), .ir(ir), .ir_valid(ir_valid),
        .pc(pc), .busy(busy), .fetch_err(fetch_err)
    );

    typedef struct {
        logic rst, rd, inc, jmp;
        logic [7:0] ja;
        logic rv;
        logic [15:0] rdat;
        logic [7:0] e_pc;
        logic e_busy, e_rden;
        logic [7:0] e_addr;
        logic [15:0] e_ir;
        logic e_v, e_err;
    } vec_t;
    vec_t vt[14];

    task automatic cyc(input logic rst, rd, inc, jmp, input logic [7:0] ja, input logic rv, input logic [15:0] rdat);
        reset = rst; imem_read = rd; pc_inc = inc; jump = jmp; jump_addr = ja; imem_rvalid = rv; imem_rdata = rdat;
        @(posedge clk);
        #1;
        if (imem_rd_en) rd_cnt++;
        reset = 1'b0; imem_read = 1'b0; pc_inc = 1'b0; jump = 1'b0; jump_addr = '0; imem_rvalid = 1'b0; imem_rdata = '0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 8'h00, 0, 16'h0000);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = '{1, 1, 1, 1, 8'h55, 1, 16'h7777, 8'h00, 0, 0, 8'h00, 16'h0000, 0, 0};
        vt[1]  = '{0, 0, 0, 0, 8'h00, 0, 16'h0000, 8'h00, 0, 0, 8'h00, 16'h0000, 0, 0};
        vt[2]  = '{0, 1, 0, 0, 8'h00, 0, 16'h0000, 8'h00, 1, 1, 8'h00, 16'h0000, 0, 0};
        vt[3]  = '{0, 0, 0, 0, 8'h00, 0, 16'h0000, 8'h00, 1, 0, 8'h00, 16'h0000, 0, 0};
        vt[4]  = '{0, 0, 0, 0, 8'h00, 1, 16'hA5C3, 8'h00, 0, 0, 8'h00, 16'hA5C3, 1, 0};
        vt[5]  = '{0, 0, 0, 0, 8'h00, 1, 16'hFFFF, 8'h00, 0, 0, 8'h00, 16'hA5C3, 0, 0};
        vt[6]  = '{0, 0, 0, 1, 8'hFF, 0, 16'h0000, 8'hFF, 0, 0, 8'h00, 16'hA5C3, 0, 0};
        vt[7]  = '{0, 0, 1, 0, 8'h00, 0, 16'h0000, 8'h00, 0, 0, 8'h00, 16'hA5C3, 0, 0};
        vt[8]  = '{0, 0, 1, 1, 8'h3C, 0, 16'h0000, 8'h3C, 0, 0, 8'h00, 16'hA5C3, 0, 0};
        vt[9]  = '{0, 0, 1, 0, 8'h00, 0, 16'h0000, 8'h3D, 0, 0, 8'h00, 16'hA5C3, 0, 0};
        vt[10] = '{0, 1, 0, 0, 8'h00, 0, 16'h0000, 8'h3D, 1, 1, 8'h3D, 16'hA5C3, 0, 0};
        vt[11] = '{0, 0, 1, 0, 8'h00, 1, 16'h1111, 8'h3E, 1, 0, 8'h3D, 16'hA5C3, 0, 0};
        vt[12] = '{0, 0, 0, 0, 8'h00, 1, 16'hBEEF, 8'h3E, 0, 0, 8'h3D, 16'hBEEF, 1, 0};
        vt[13] = '{0, 0, 0, 0, 8'h00, 0, 16'h0000, 8'h3E, 0, 0, 8'h3D, 16'hBEEF, 0, 0};
        for (int i = 0; i < 14; i++) begin
            cyc(vt[i].rst, vt[i].rd, vt[i].inc, vt[i].jmp, vt[i].ja, vt[i].rv, vt[i].rdat);
            n_vec++;
            if ({pc, busy, imem_rd_en, imem_addr, ir, ir_valid, fetch_err} !==
                {vt[i].e_pc, vt[i].e_busy, vt[i].e_rden, vt[i].e_addr, vt[i].e_ir, vt[i].e_v, vt[i].e_err}) begin
                n_bad++;
                $display("FAIL vec%0d: got pc=%h busy=%b rd_en=%b addr=%h ir=%h v=%b err=%b, expected pc=%h busy=%b rd_en=%b addr=%h ir=%h v=%b err=%b",
                    i, pc, busy, imem_rd_en, imem_addr, ir, ir_valid, fetch_err,
                    vt[i].e_pc, vt[i].e_busy, vt[i].e_rden, vt[i].e_addr, vt[i].e_ir, vt[i].e_v, vt[i].e_err);
            end
        end

        // jump during WAIT flushes the fetch; late rvalid is dropped
        cyc(0, 1, 0, 0, 8'h00, 0, 16'h0000);
        idle(1);
        cyc(0, 0, 0, 1, 8'h20, 0, 16'h0000);
        chk("flush_busy", busy, 0);
        chk("flush_pc", pc, 8'h20);
        chk("flush_no_valid", ir_valid, 0);
        cyc(0, 0, 0, 0, 8'h00, 1, 16'h1234);
        chk("flush_ir", ir, 16'hBEEF);
        chk("flush_late_valid", ir_valid, 0);
        cyc(0, 1, 0, 0, 8'h00, 0, 16'h0000);
        chk("refetch_addr", {imem_rd_en, imem_addr}, {1'b1, 8'h20});
        idle(1);
        cyc(0, 0, 0, 0, 8'h00, 1, 16'h5678);
        chk("refetch_ir", {ir_valid, ir}, {1'b1, 16'h5678});

        // two reads while WAIT yield exactly one extra fetch
        rd_cnt = 0;
        cyc(0, 1, 0, 0, 8'h00, 0, 16'h0000);
        idle(1);
        cyc(0, 1, 0, 0, 8'h00, 0, 16'h0000);
        cyc(0, 1, 0, 0, 8'h00, 0, 16'h0000);
        idle(1);
        cyc(0, 0, 0, 0, 8'h00, 1, 16'h0001);
        chk("pend_first", {ir_valid, ir}, {1'b1, 16'h0001});
        idle(1);
        chk("pend_req", {busy, imem_rd_en}, 2'b11);
        idle(1);
        cyc(0, 0, 0, 0, 8'h00, 1, 16'h0002);
        chk("pend_second", {ir_valid, ir}, {1'b1, 16'h0002});
        idle(3);
        chk("pend_idle", busy, 0);
        chk("pend_rd_count", rd_cnt, 2);

        // pending request survives a jump flush
        cyc(0, 1, 0, 0, 8'h00, 0, 16'h0000);
        idle(1);
        cyc(0, 1, 0, 0, 8'h00, 0, 16'h0000);
        cyc(0, 0, 0, 1, 8'h40, 0, 16'h0000);
        chk("jpend_flush", {busy, pc}, {1'b0, 8'h40});
        idle(1);
        chk("jpend_req", {busy, imem_rd_en, imem_addr}, {2'b11, 8'h40});
        idle(1);
        cyc(0, 0, 0, 0, 8'h00, 1, 16'h4444);
        chk("jpend_ir", {ir_valid, ir}, {1'b1, 16'h4444});

        // timeout after 16 WAIT cycles, then fetching still works
        cyc(0, 1, 0, 0, 8'h00, 0, 16'h0000);
        idle(1);
        idle(15);
        chk("to_still_wait", {busy, fetch_err}, 2'b10);
        idle(1);
        chk("to_err", {busy, fetch_err, ir_valid}, 3'b010);
        chk("to_ir", ir, 16'h4444);
        cyc(0, 1, 0, 0, 8'h00, 0, 16'h0000);
        idle(1);
        cyc(0, 0, 0, 0, 8'h00, 1, 16'h0C0C);
        chk("to_refetch", {ir_valid, ir, fetch_err}, {1'b1, 16'h0C0C, 1'b1});
        idle(2);
        chk("to_sticky", fetch_err, 1);

        // reset in WAIT, then a late rvalid
        cyc(0, 1, 0, 0, 8'h00, 0, 16'h0000);
        idle(1);
        cyc(1, 0, 0, 0, 8'h00, 0, 16'h0000);
        chk("rst_wait", {pc, busy, imem_rd_en, imem_addr, ir, ir_valid, fetch_err}, 0);
        cyc(0, 0, 0, 0, 8'h00, 1, 16'h9999);
        chk("rst_late_rvalid", {pc, busy, imem_rd_en, imem_addr, ir, ir_valid, fetch_err}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter BUS_WIDTH, default 16, instruction word width.
REQ-002 Parameter PC_WIDTH, default 8, program-counter and instruction-address width.
REQ-003 Parameter TIMEOUT, default 16, maximum cycles spent in WAIT before a fetch error.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 pc_inc  input  1  increment-PC command from the control unit.
REQ-007 imem_read  input  1  fetch command from the control unit.
REQ-008 jump  input  1  load-PC command from the control unit.
REQ-009 jump_addr  input  PC_WIDTH  jump target.
REQ-010 imem_addr  output  PC_WIDTH  instruction-memory address.
REQ-011 imem_rd_en  output  1  instruction-memory read strobe.
REQ-012 imem_rdata  input  BUS_WIDTH  instruction-memory read data.
REQ-013 imem_rvalid  input  1  read data valid.
REQ-014 ir  output  BUS_WIDTH  instruction register, fed to the control unit.
REQ-015 ir_valid  output  1  single-cycle pulse marking an ir update.
REQ-016 pc  output  PC_WIDTH  current program counter.
REQ-017 busy  output  1  high whenever the FSM is not in IDLE.
REQ-018 fetch_err  output  1  sticky timeout flag.

Function
REQ-019 The FSM SHALL have states IDLE, REQ and WAIT; all outputs are registered except busy, which is decoded from state.
REQ-020 In IDLE, imem_read=1 or pending=1 SHALL move the FSM to REQ and clear pending.
REQ-021 The REQ state SHALL last exactly one cycle, with imem_rd_en=1 and imem_addr latched from pc, then SHALL advance to WAIT.
REQ-022 In WAIT, imem_rvalid=1 SHALL load ir from imem_rdata, pulse ir_valid for one cycle and return the FSM to IDLE.
REQ-023 imem_rvalid SHALL be ignored in IDLE and REQ.
REQ-024 Latency: imem_read sampled at edge N SHALL give imem_rd_en high in cycle N+1; with rvalid sampled at edge N+2, ir_valid SHALL be high in cycle N+3.
REQ-025 imem_read while busy SHALL set a single pending flag; further requests while pending is already set SHALL be dropped.
REQ-026 pc_inc SHALL set pc to pc+1 modulo 2^PC_WIDTH in any state, so all-ones wraps to 0.
REQ-027 jump SHALL set pc to jump_addr in any state; when jump and pc_inc are both high, jump SHALL win.
REQ-028 A PC change during WAIT SHALL NOT alter imem_addr or the in-flight fetch.
REQ-029 jump during REQ or WAIT SHALL flush the in-flight fetch: the FSM returns to IDLE, ir is unchanged, no ir_valid is issued, and pending is preserved.
REQ-030 A WAIT cycle counter SHALL set fetch_err=1 after TIMEOUT consecutive cycles without rvalid; the FSM then returns to IDLE and ir is unchanged.
REQ-031 fetch_err SHALL stay high until reset; fetching continues normally while it is set.

Reset
REQ-032 While reset=1 at a clock edge, the block SHALL set state=IDLE, pc=0, ir=0, ir_valid=0, imem_rd_en=0, imem_addr=0, fetch_err=0, pending=0 and the timeout counter to 0.
REQ-033 Reset SHALL override every simultaneous command.
REQ-034 After reset during WAIT, a late rvalid SHALL be ignored.

Structure
REQ-035 A shared package cpu_pkg SHALL hold BUS_WIDTH, PC_WIDTH, TIMEOUT defaults and the fetch-state enumeration.
REQ-036 One sub-module, pc_reg, SHALL implement the program counter with inc, load and reset; the FSM, pending flag, timeout counter and ir SHALL reside in instr_fetch.

Verification
REQ-037 After reset: imem_read pulse, memory returns 16'hA5C3 one cycle after imem_rd_en -> imem_addr=0, ir=16'hA5C3, ir_valid a single-cycle pulse at N+3.
REQ-038 pc=8'hFF with pc_inc=1 -> pc=8'h00; jump=1, jump_addr=8'h3C and pc_inc=1 in the same cycle -> pc=8'h3C.
REQ-039 jump to 8'h20 during WAIT, then rvalid with 16'h1234 -> ir unchanged, no ir_valid, busy=0; the next fetch reads address 8'h20.
REQ-040 Two imem_read pulses during WAIT -> exactly one additional fetch, issued after the first completes.
REQ-041 No rvalid for 16 WAIT cycles -> fetch_err=1, busy=0; a subsequent fetch succeeds and fetch_err stays 1 until reset.
REQ-042 reset asserted in WAIT, then rvalid one cycle later -> all outputs at reset values, ir stays 0.
